crab_mem_responder: RTL

CRAB_MEM_RESPONDER -- requirements
Module: crab_mem_responder

---
 rtl/crab_mem_pkg.sv | 14 +
 rtl/crab_mem_lanes.sv | 30 +++
 rtl/crab_mem_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/crab_mem_pkg.sv
// Shared types for the crab memory responder: FSM state encoding and io_mode store sizes.
package crab_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        RESP
    } state_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/crab_mem_lanes.sv
// Combinational byte-lane steering: store byte enables, left-shifted store word, right-rotated read word.
module crab_mem_lanes
    import crab_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  io_mode,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rword_in,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [3:0] base_en;
    logic [4:0] sh;

    always_comb begin
        case (io_mode)
            SIZE_BYTE: base_en = 4'b0001;
            SIZE_HALF: base_en = 4'b0011;
            default:   base_en = 4'b1111;
        endcase
        // Shifting a 4-bit vector drops lanes past byte 3, so stores never spill into the next word.
        byte_en = base_en << addr_lo;
        sh      = {addr_lo, 3'b000};
        wword   = wdata_in << sh;
        rdata   = (rword_in >> sh) | (rword_in << (6'd32 - {1'b0, sh}));
    end

endmodule

// File: rtl/crab_mem_responder.sv
// Toggle-handshake memory responder with READ_LATENCY read pipeline and single-cycle stores.
// Optional macro CRAB_MEM_RANGE_CHECK_EN adds mem_err and blocks out-of-range accesses.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a request; stores are written here in one clock
// READ_WAIT | read address captured, latency counter running down to zero
// RESP      | response presented until the initiator toggles mem_ack
module crab_mem_responder
    import crab_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_addr_valid,
    input  logic [31:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [31:0] mem_data,
    input  logic [2:0]  io_mode,
    input  logic        mem_ack,
    output logic        mem_ready,
    output logic [31:0] mem_input,
    output logic        mem_write_done,
    output logic        mem_addr_ack
`ifdef CRAB_MEM_RANGE_CHECK_EN
    ,
    output logic        mem_err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_d, done_d, ack_d;
    logic [31:0]     input_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic            oor_q, oor_d;
    logic            req_oor;

    logic [31:0]     mem_array [DEPTH_WORDS];
    logic [1:0]      lane_lo;
    logic [3:0]      byte_en;
    logic [31:0]     wword, rword, rdata;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;

`ifdef CRAB_MEM_RANGE_CHECK_EN
    assign req_oor = |mem_addr[31:AW+2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= (state_q == IDLE && mem_addr_valid && mem_data_valid && req_oor)
                    || (state_q == READ_WAIT && cnt_q == '0 && oor_q);
        end
    end
`else
    logic addr_hi_unused;
    assign req_oor        = 1'b0;
    assign addr_hi_unused = |mem_addr[31:AW+2];
`endif

    assign wr_idx  = mem_addr[AW+1:2];
    assign wr_en   = (state_q == IDLE) && mem_addr_valid && mem_data_valid && !req_oor;
    assign lane_lo = (state_q == IDLE) ? mem_addr[1:0] : addr_q[1:0];
    assign rword   = mem_array[addr_q[AW+1:2]];

    crab_mem_lanes u_lanes (
        .addr_lo  (lane_lo),
        .io_mode  (io_mode),
        .wdata_in (mem_data),
        .rword_in (rword),
        .byte_en  (byte_en),
        .wword    (wword),
        .rdata    (rdata)
    );

    // Array is deliberately outside the reset domain; a store is a single edge so it is all-or-nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_array[wr_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = mem_ready;
        done_d  = mem_write_done;
        ack_d   = mem_addr_ack;
        input_d = mem_input;
        addr_d  = addr_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (mem_addr_valid) begin
                    if (mem_data_valid) begin
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        ack_d   = mem_ack;
                        state_d = RESP;
                    end else begin
                        addr_d  = mem_addr[AW+1:0];
                        oor_d   = req_oor;
                        cnt_d   = CNT_LOAD;
                        state_d = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (cnt_q == '0) begin
                    input_d = oor_q ? 32'h0 : rdata;
                    ready_d = 1'b1;
                    ack_d   = mem_ack;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (mem_ack != mem_addr_ack) begin
                    ready_d = 1'b0;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mem_ready      <= 1'b0;
            mem_write_done <= 1'b0;
            mem_addr_ack   <= 1'b0;
            mem_input      <= '0;
            addr_q         <= '0;
            oor_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_ready      <= ready_d;
            mem_write_done <= done_d;
            mem_addr_ack   <= ack_d;
            mem_input      <= input_d;
            addr_q         <= addr_d;
            oor_q          <= oor_d;
        end
    end

endmodule
